// File: rtl/vend_fsm_param.sv
// -----------------------------------------------------------------------------
// vend_fsm_param
//   Parametrised vending-machine controller. A Moore FSM accumulates coin
//   credit, dispenses once credit reaches PRICE, and then returns any change.
//   A cancel returns the accumulated credit, including coins that arrive on
//   the same edge as the cancel.
//
// Parameters
//   PRICE        item price in credit units (>= 1)
//   COIN0_VAL    value of coin strobe D_in[0]
//   COIN1_VAL    value of coin strobe D_in[1]
//   CREDIT_W     credit/change width; must hold PRICE-1+COIN0_VAL+COIN1_VAL
//   DISP_CYCLES  number of cycles D_out stays high (>= 1)
//
// Ports
//   Clk           in   rising-edge clock
//   Reset         in   asynchronous, active-high reset
//   D_in[1:0]     in   coin strobes, sampled every cycle (both may be set)
//   Cancel        in   refund request
//   D_out         out  dispense strobe, high in DISPENSE
//   Change_valid  out  one-cycle strobe that qualifies Change
//   Change        out  change/refund amount; 0 while Change_valid is low
//   Credit        out  current accumulated credit
//   Busy          out  high in DISPENSE/CHANGE; coins and Cancel are ignored
//
// All outputs decode from registers only. There is no combinational path
// from D_in or Cancel to any output.
// -----------------------------------------------------------------------------
module vend_fsm_param #(
    parameter int PRICE       = 4,
    parameter int COIN0_VAL   = 1,
    parameter int COIN1_VAL   = 2,
    parameter int CREDIT_W    = 4,
    parameter int DISP_CYCLES = 1
) (
    input  logic                Clk,
    input  logic                Reset,
    input  logic [1:0]          D_in,
    input  logic                Cancel,
    output logic                D_out,
    output logic                Change_valid,
    output logic [CREDIT_W-1:0] Change,
    output logic [CREDIT_W-1:0] Credit,
    output logic                Busy
);

    // The sum is one bit wider than credit, so credit + coin never wraps.
    localparam int SUM_W = CREDIT_W + 1;
    localparam int CNT_W = $clog2(DISP_CYCLES + 1);

    localparam logic [SUM_W-1:0] COIN0_S = SUM_W'(COIN0_VAL);
    localparam logic [SUM_W-1:0] COIN1_S = SUM_W'(COIN1_VAL);
    localparam logic [SUM_W-1:0] PRICE_S = SUM_W'(PRICE);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DISP_CYCLES - 1);

    if (PRICE - 1 + COIN0_VAL + COIN1_VAL >= 2 ** CREDIT_W) begin : g_err_width
        $error("vend_fsm_param: CREDIT_W too small for PRICE-1+COIN0_VAL+COIN1_VAL");
    end
    if (DISP_CYCLES < 1) begin : g_err_disp
        $error("vend_fsm_param: DISP_CYCLES must be >= 1");
    end
    if (PRICE < 1) begin : g_err_price
        $error("vend_fsm_param: PRICE must be >= 1");
    end

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ACCUM    = 2'd1,
        S_DISPENSE = 2'd2,
        S_CHANGE   = 2'd3
    } state_e;

    state_e              state_q,    state_d;
    logic [CREDIT_W-1:0] credit_q,   credit_d;
    logic [CREDIT_W-1:0] change_q,   change_d;
    logic [CNT_W-1:0]    disp_cnt_q, disp_cnt_d;

    logic [SUM_W-1:0]    coin;
    logic [SUM_W-1:0]    sum;

    // NOTE: state registers use non-blocking assignments, so every flop
    // samples the values from before the edge, whatever the statement order.
    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= S_IDLE;
            credit_q   <= '0;
            change_q   <= '0;
            disp_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            credit_q   <= credit_d;
            change_q   <= change_d;
            disp_cnt_q <= disp_cnt_d;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case statement.
        // A path that does not assign a variable would infer a latch.
        state_d    = state_q;
        credit_d   = credit_q;
        change_d   = change_q;
        disp_cnt_d = disp_cnt_q;

        coin = (D_in[0] ? COIN0_S : '0) + (D_in[1] ? COIN1_S : '0);
        sum  = {1'b0, credit_q} + coin;

        case (state_q)
            S_IDLE, S_ACCUM: begin
                if (Cancel) begin
                    // Coins that arrive with the cancel are refunded, not lost.
                    // If there is nothing to refund, the cancel does nothing.
                    if (sum != '0) begin
                        change_d = CREDIT_W'(sum);
                        credit_d = '0;
                        state_d  = S_CHANGE;
                    end
                end else if (sum >= PRICE_S) begin
                    change_d   = CREDIT_W'(sum - PRICE_S);
                    credit_d   = '0;
                    disp_cnt_d = CNT_LOAD;
                    state_d    = S_DISPENSE;
                end else begin
                    credit_d = CREDIT_W'(sum);
                    state_d  = (sum != '0) ? S_ACCUM : S_IDLE;
                end
            end

            S_DISPENSE: begin
                // The counter loads DISP_CYCLES-1, so D_out stays high for
                // exactly DISP_CYCLES cycles.
                if (disp_cnt_q == '0) begin
                    state_d = (change_q != '0) ? S_CHANGE : S_IDLE;
                end else begin
                    disp_cnt_d = disp_cnt_q - CNT_W'(1);
                end
            end

            S_CHANGE: begin
                change_d = '0;
                state_d  = S_IDLE;
            end

            default: begin
                state_d    = S_IDLE;
                credit_d   = '0;
                change_d   = '0;
                disp_cnt_d = '0;
            end
        endcase
    end

    assign D_out        = (state_q == S_DISPENSE);
    assign Change_valid = (state_q == S_CHANGE);
    assign Change       = (state_q == S_CHANGE) ? change_q : '0;
    assign Credit       = credit_q;
    assign Busy         = (state_q == S_DISPENSE) || (state_q == S_CHANGE);

endmodule

// File: tb/tb_vend_fsm_param.sv
// -----------------------------------------------------------------------------
// tb_vend_fsm_param
//   Runs three configurations of vend_fsm_param in parallel from the same
//   stimulus:
//     u0 : defaults (PRICE=4, DISP_CYCLES=1)
//     u1 : DISP_CYCLES=3
//     u2 : PRICE=7
//   The reference model keeps one credit value per configuration and a queue
//   of scheduled output cycles. A purchase or refund pushes the dispense and
//   change cycles it will produce. While that queue is not empty, the machine
//   is busy.
// -----------------------------------------------------------------------------
module tb_vend_fsm_param;

    logic       Clk;
    logic       Reset;
    logic [1:0] D_in;
    logic       Cancel;

    logic       d_out  [3];
    logic       cv     [3];
    logic [3:0] chg    [3];
    logic [3:0] credit [3];
    logic       busy   [3];

    vend_fsm_param u0 (
        .Clk(Clk), .Reset(Reset), .D_in(D_in), .Cancel(Cancel),
        .D_out(d_out[0]), .Change_valid(cv[0]), .Change(chg[0]),
        .Credit(credit[0]), .Busy(busy[0])
    );

    vend_fsm_param #(.DISP_CYCLES(3)) u1 (
        .Clk(Clk), .Reset(Reset), .D_in(D_in), .Cancel(Cancel),
        .D_out(d_out[1]), .Change_valid(cv[1]), .Change(chg[1]),
        .Credit(credit[1]), .Busy(busy[1])
    );

    vend_fsm_param #(.PRICE(7), .CREDIT_W(4)) u2 (
        .Clk(Clk), .Reset(Reset), .D_in(D_in), .Cancel(Cancel),
        .D_out(d_out[2]), .Change_valid(cv[2]), .Change(chg[2]),
        .Credit(credit[2]), .Busy(busy[2])
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    // ---------------- reference model ----------------
    typedef struct {
        bit dout;
        bit cv;
        int chg;
    } out_t;

    int   m_price [3] = '{4, 4, 7};
    int   m_c0    [3] = '{1, 1, 1};
    int   m_c1    [3] = '{2, 2, 2};
    int   m_disp  [3] = '{1, 3, 1};
    int   m_credit[3];
    out_t mq [3][$];

    int total = 0;
    int bad   = 0;

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            mq[i].delete();
            m_credit[i] = 0;
        end
    endtask

    task automatic model_edge(input logic [1:0] din, input logic cancel);
        for (int i = 0; i < 3; i++) begin
            if (mq[i].size() != 0) begin
                void'(mq[i].pop_front());
            end else begin
                int   coin;
                int   sum;
                out_t e;
                coin = (din[0] ? m_c0[i] : 0) + (din[1] ? m_c1[i] : 0);
                sum  = m_credit[i] + coin;
                if (cancel) begin
                    if (sum != 0) begin
                        e.dout = 1'b0; e.cv = 1'b1; e.chg = sum;
                        mq[i].push_back(e);
                        m_credit[i] = 0;
                    end
                end else if (sum >= m_price[i]) begin
                    for (int k = 0; k < m_disp[i]; k++) begin
                        e.dout = 1'b1; e.cv = 1'b0; e.chg = 0;
                        mq[i].push_back(e);
                    end
                    if (sum - m_price[i] != 0) begin
                        e.dout = 1'b0; e.cv = 1'b1; e.chg = sum - m_price[i];
                        mq[i].push_back(e);
                    end
                    m_credit[i] = 0;
                end else begin
                    m_credit[i] = sum;
                end
            end
        end
    endtask

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int i = 0; i < 3; i++) begin
            int e_dout, e_cv, e_chg, e_cr, e_busy;
            if (mq[i].size() != 0) begin
                e_dout = int'(mq[i][0].dout);
                e_cv   = int'(mq[i][0].cv);
                e_chg  = mq[i][0].chg;
                e_cr   = 0;
                e_busy = 1;
            end else begin
                e_dout = 0; e_cv = 0; e_chg = 0; e_busy = 0;
                e_cr   = m_credit[i];
            end
            chk($sformatf("%s.u%0d.d_out",  tag, i), 32'(d_out[i]),  32'(e_dout));
            chk($sformatf("%s.u%0d.cv",     tag, i), 32'(cv[i]),     32'(e_cv));
            chk($sformatf("%s.u%0d.change", tag, i), 32'(chg[i]),    32'(e_chg));
            chk($sformatf("%s.u%0d.credit", tag, i), 32'(credit[i]), 32'(e_cr));
            chk($sformatf("%s.u%0d.busy",   tag, i), 32'(busy[i]),   32'(e_busy));
        end
    endtask

    // Called at a negedge: drive inputs, let the posedge sample them, then
    // compare at the following negedge.
    task automatic step(input logic [1:0] din, input logic cancel, input string tag);
        D_in   = din;
        Cancel = cancel;
        @(posedge Clk);
        model_edge(din, cancel);
        @(negedge Clk);
        check_all(tag);
    endtask

    task automatic do_reset();
        @(negedge Clk);
        Reset  = 1'b1;
        D_in   = 2'b00;
        Cancel = 1'b0;
        #2;
        model_reset();
        check_all("rst");
        @(negedge Clk);
        Reset = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        Reset  = 1'b1;
        D_in   = 2'b00;
        Cancel = 1'b0;
        model_reset();

        // T1: four 1-unit coins on defaults -> credit 1,2,3, then dispense one cycle.
        do_reset();
        step(2'b01, 1'b0, "t1.c1"); chk("t1.credit1", 32'(credit[0]), 32'd1);
        step(2'b01, 1'b0, "t1.c2"); chk("t1.credit2", 32'(credit[0]), 32'd2);
        step(2'b01, 1'b0, "t1.c3"); chk("t1.credit3", 32'(credit[0]), 32'd3);
        step(2'b01, 1'b0, "t1.c4"); chk("t1.dout_on", 32'(d_out[0]),  32'd1);
        step(2'b00, 1'b0, "t1.i1");
        chk("t1.dout_off", 32'(d_out[0]), 32'd0);
        chk("t1.no_cv",    32'(cv[0]),    32'd0);
        chk("t1.idle",     32'(busy[0]),  32'd0);
        for (int k = 0; k < 4; k++) step(2'b00, 1'b0, "t1.drain");

        // T2: 3 + 2 = 5 -> dispense, then change of 1.
        do_reset();
        step(2'b11, 1'b0, "t2.c1");
        step(2'b10, 1'b0, "t2.c2"); chk("t2.dout", 32'(d_out[0]), 32'd1);
        step(2'b00, 1'b0, "t2.i1");
        chk("t2.cv",  32'(cv[0]),  32'd1);
        chk("t2.chg", 32'(chg[0]), 32'd1);
        step(2'b00, 1'b0, "t2.i2");
        chk("t2.credit", 32'(credit[0]), 32'd0);
        chk("t2.busy",   32'(busy[0]),   32'd0);
        for (int k = 0; k < 4; k++) step(2'b00, 1'b0, "t2.drain");

        // T3: a cancel on the same edge as a coin refunds both coins.
        do_reset();
        step(2'b01, 1'b0, "t3.c1");
        step(2'b10, 1'b1, "t3.cancel");
        chk("t3.no_dout", 32'(d_out[0]), 32'd0);
        chk("t3.cv",      32'(cv[0]),    32'd1);
        chk("t3.refund",  32'(chg[0]),   32'd3);
        for (int k = 0; k < 4; k++) step(2'b00, 1'b0, "t3.drain");

        // T4: u1 dispenses for 3 cycles and ignores coins held during DISPENSE.
        do_reset();
        step(2'b10, 1'b0, "t4.c1");
        step(2'b10, 1'b0, "t4.c2");
        chk("t4.dout1", 32'(d_out[1]), 32'd1);
        chk("t4.busy1", 32'(busy[1]),  32'd1);
        step(2'b11, 1'b0, "t4.h1"); chk("t4.dout2", 32'(d_out[1]), 32'd1);
        step(2'b11, 1'b0, "t4.h2"); chk("t4.dout3", 32'(d_out[1]), 32'd1);
        step(2'b11, 1'b0, "t4.h3");
        chk("t4.dout_end", 32'(d_out[1]),  32'd0);
        chk("t4.credit",   32'(credit[1]), 32'd0);
        chk("t4.busy_end", 32'(busy[1]),   32'd0);
        for (int k = 0; k < 5; k++) step(2'b00, 1'b0, "t4.drain");

        // T5: a reset asserted between edges clears outputs without waiting for Clk.
        do_reset();
        step(2'b01, 1'b0, "t5.c1");
        step(2'b10, 1'b0, "t5.c2");
        chk("t5.credit3", 32'(credit[0]), 32'd3);
        #2 Reset = 1'b1;
        #1;
        model_reset();
        chk("t5.async_credit", 32'(credit[0]), 32'd0);
        check_all("t5.async");
        @(negedge Clk);
        Reset = 1'b0;
        step(2'b01, 1'b0, "t5.after");
        chk("t5.fresh_credit", 32'(credit[0]), 32'd1);

        // T6: u2 (PRICE=7): 3, 6, 9 -> dispense, change 2, then a cancel with no credit.
        do_reset();
        step(2'b11, 1'b0, "t6.c1"); chk("t6.credit3", 32'(credit[2]), 32'd3);
        step(2'b11, 1'b0, "t6.c2"); chk("t6.credit6", 32'(credit[2]), 32'd6);
        step(2'b11, 1'b0, "t6.c3"); chk("t6.dout",    32'(d_out[2]),  32'd1);
        step(2'b00, 1'b0, "t6.i1");
        chk("t6.cv",  32'(cv[2]),  32'd1);
        chk("t6.chg", 32'(chg[2]), 32'd2);
        for (int k = 0; k < 4; k++) step(2'b00, 1'b0, "t6.drain");
        step(2'b00, 1'b1, "t6.cancel0");
        chk("t6.no_refund", 32'(cv[2]), 32'd0);

        // Random traffic, with occasional resets.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            logic [1:0] din;
            logic       c;
            din = 2'($urandom_range(0, 3));
            c   = ($urandom_range(0, 7) == 0);
            if ($urandom_range(0, 99) == 0) do_reset();
            step(din, c, $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
